clock_rate_controller: RTL and testbench

Sequencing controller for the divided clock enables (main, ÷2, ÷4) that the clock generator produces. It runs one free-running divide counter and emits single-cycle tick enables at a programmable rate (÷1/÷2/÷4/÷8), plus fixed ÷2 and ÷4 ticks. Rate changes use a req/ack handshake and take effect only at the common counter wrap, so no shortened or stretched tick period ever appears. Downstream sequential logic uses the ticks as clock enables on the single system clock; no derived clocks are created.

---
 rtl/clock_rate_pkg.sv | 42 ++++
 rtl/rate_div_counter.sv | 36 +++
 rtl/clock_rate_controller.sv | 89 ++++++++
 tb/tb_clock_rate_controller.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/clock_rate_pkg.sv
// Shared definitions for the clock rate controller.
//   DIV_W       : width of the free-running divide counter
//   rate_sel_e  : rate encodings (divide by 1/2/4/8)
//   state_e     : rate-switch handshake FSM states
//   match_mask  : low-bit mask that must be all ones for a rate to tick
//   rate_match  : tick decode for a rate at a given counter value
package clock_rate_pkg;

  localparam int DIV_W = 3;
  // Every rate ticks on this value, so the switch can happen here without
  // clipping or stretching any period.
  localparam logic [DIV_W-1:0] DIV_WRAP = 3'd7;

  typedef enum logic [1:0] {
    SEL_DIV1 = 2'd0,
    SEL_DIV2 = 2'd1,
    SEL_DIV4 = 2'd2,
    SEL_DIV8 = 2'd3
  } rate_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_ALIGN = 2'd1,
    ST_ACK        = 2'd2
  } state_e;

  function automatic logic [DIV_W-1:0] match_mask(input logic [1:0] s);
    logic [DIV_W-1:0] m;
    case (s)
      SEL_DIV1: m = 3'b000;
      SEL_DIV2: m = 3'b001;
      SEL_DIV4: m = 3'b011;
      default:  m = 3'b111;
    endcase
    return m;
  endfunction

  function automatic logic rate_match(input logic [1:0] s, input logic [DIV_W-1:0] cnt);
    return (cnt & match_mask(s)) == match_mask(s);
  endfunction

endpackage

// File: rtl/rate_div_counter.sv
// Free-running divide counter plus registered tick decode.
//   clk, resetn : system clock, async active-low reset
//   run         : 1 = count and tick, 0 = freeze counter, ticks forced low
//   cur_sel     : rate in effect for the programmable tick
//   div_cnt     : divide counter value (wraps 7 -> 0)
//   tick        : one-cycle enable at the cur_sel rate
//   tick2/tick4 : fixed divide-by-2 / divide-by-4 enables
module rate_div_counter
  import clock_rate_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             run,
  input  logic [1:0]       cur_sel,
  output logic [DIV_W-1:0] div_cnt,
  output logic             tick,
  output logic             tick2,
  output logic             tick4
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_cnt <= '0;
      tick    <= 1'b0;
      tick2   <= 1'b0;
      tick4   <= 1'b0;
    end else begin
      // Decode the pre-increment value: a tick lands one cycle after its match.
      tick  <= run & rate_match(cur_sel, div_cnt);
      tick2 <= run & rate_match(SEL_DIV2, div_cnt);
      tick4 <= run & rate_match(SEL_DIV4, div_cnt);
      if (run) div_cnt <= div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/clock_rate_controller.sv
// Clock-enable rate controller: programmable tick (div 1/2/4/8) plus fixed
// div-2/div-4 ticks from one counter. Rate changes are requested with
// req/sel, acknowledged with a one-cycle ack, and applied only at the
// common counter wrap so every tick period is whole.
//   clk, resetn : system clock, async active-low reset
//   run         : 1 = advance and tick, 0 = freeze
//   req, sel    : rate-change request and requested rate (taken when idle)
//   busy        : request accepted, switch pending
//   ack         : one-cycle pulse, new rate in effect
//   cur_sel     : rate in effect
//   tick/tick2/tick4 : enable pulses
//   tick_cnt    : ticks since last rate switch (wraps)
module clock_rate_controller
  import clock_rate_pkg::*;
#(
  parameter logic [1:0] RESET_SEL = 2'd0,
  parameter int         TCNT_W    = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              run,
  input  logic              req,
  input  logic [1:0]        sel,
  output logic              busy,
  output logic              ack,
  output logic [1:0]        cur_sel,
  output logic              tick,
  output logic              tick2,
  output logic              tick4,
  output logic [TCNT_W-1:0] tick_cnt
);

  state_e           state, state_nxt;
  logic [1:0]       pend_sel;
  logic [DIV_W-1:0] div_cnt;
  logic             accept, do_switch;

  rate_div_counter u_div (
    .clk     (clk),
    .resetn  (resetn),
    .run     (run),
    .cur_sel (cur_sel),
    .div_cnt (div_cnt),
    .tick    (tick),
    .tick2   (tick2),
    .tick4   (tick4)
  );

  assign accept    = (state == ST_IDLE) && req && (sel != cur_sel);
  assign do_switch = (state == ST_WAIT_ALIGN) && run && (div_cnt == DIV_WRAP);

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    ack       = 1'b0;
    case (state)
      ST_IDLE: begin
        // A request for the rate already in effect is acked straight away.
        if (req) state_nxt = (sel != cur_sel) ? ST_WAIT_ALIGN : ST_ACK;
      end
      ST_WAIT_ALIGN: begin
        busy = 1'b1;
        if (do_switch) state_nxt = ST_ACK;
      end
      ST_ACK: begin
        ack       = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      pend_sel <= 2'd0;
      cur_sel  <= RESET_SEL;
      tick_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (accept)    pend_sel <= sel;
      if (do_switch) cur_sel  <= pend_sel;
      // Clear on the switch edge wins over a coincident tick.
      if (do_switch)  tick_cnt <= '0;
      else if (tick) tick_cnt <= tick_cnt + TCNT_W'(1);
    end
  end

endmodule

// File: tb/tb_clock_rate_controller.sv
// Directed bench for clock_rate_controller. Inputs change 1 ns after a rising
// edge and outputs are sampled at the same point. Edge numbers (En) in the
// comments count rising edges after reset release; after En the divide
// counter holds n mod 8 while run has stayed high.
module tb_clock_rate_controller;

  logic       clk = 1'b0;
  logic       resetn, run, req;
  logic [1:0] sel;
  logic       busy, ack, tick, tick2, tick4;
  logic [1:0] cur_sel;
  logic [7:0] tick_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  clock_rate_controller #(.RESET_SEL(2'd0), .TCNT_W(8)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .run      (run),
    .req      (req),
    .sel      (sel),
    .busy     (busy),
    .ack      (ack),
    .cur_sel  (cur_sel),
    .tick     (tick),
    .tick2    (tick2),
    .tick4    (tick4),
    .tick_cnt (tick_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    resetn = 1'b0; run = 1'b1; req = 1'b0; sel = 2'd0;
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_ack", ack, 0);
    chk("rst_cur_sel", cur_sel, 0);
    chk("rst_tick", tick, 0);
    chk("rst_tick2", tick2, 0);
    chk("rst_tick4", tick4, 0);
    chk("rst_tick_cnt", tick_cnt, 0);
    #9 resetn = 1'b1;   // t=12, first edge at 15

    // div1: tick every cycle, tick2 on even n, tick4 on n%4==0
    for (int n = 1; n <= 8; n++) begin
      step();
      chk("d1_tick", tick, 1);
      chk("d1_tick2", tick2, (n % 2 == 0));
      chk("d1_tick4", tick4, (n % 4 == 0));
      chk("d1_tick_cnt", tick_cnt, n - 1);
    end

    // request div8 at div_cnt=2 (E11), switch on E16
    step(2);
    req = 1'b1; sel = 2'd3;
    step();                                     // E11
    chk("sw8_busy", busy, 1);
    chk("sw8_noack", ack, 0);
    req = 1'b0;
    for (int n = 12; n <= 15; n++) begin
      step();
      chk("sw8_wait_busy", busy, 1);
      chk("sw8_wait_noack", ack, 0);
    end
    step();                                     // E16
    chk("sw8_ack", ack, 1);
    chk("sw8_ack_busy", busy, 0);
    chk("sw8_cur_sel", cur_sel, 3);
    chk("sw8_cnt_clr", tick_cnt, 0);
    chk("sw8_last_old_tick", tick, 1);
    step();                                     // E17
    chk("sw8_ack_drop", ack, 0);
    chk("sw8_tick0", tick, 0);
    chk("sw8_cnt1", tick_cnt, 1);
    for (int n = 18; n <= 23; n++) begin
      step();
      chk("d8_gap", tick, 0);
    end
    step();                                     // E24
    chk("d8_tick", tick, 1);
    step();                                     // E25
    chk("d8_after", tick, 0);
    chk("d8_cnt", tick_cnt, 2);

    // switch to div2 (accepted E26, aligned E32)
    req = 1'b1; sel = 2'd1;
    step();
    req = 1'b0;
    chk("sw2_busy", busy, 1);
    step(6);                                    // E32
    chk("sw2_ack", ack, 1);
    chk("sw2_cur_sel", cur_sel, 1);
    chk("sw2_cnt_clr", tick_cnt, 0);
    step();                                     // E33
    chk("sw2_ack_drop", ack, 0);
    chk("sw2_cnt1", tick_cnt, 1);

    // same-rate request: ack next cycle, no busy, no clear
    req = 1'b1; sel = 2'd1;
    step();                                     // E34
    chk("same_ack", ack, 1);
    chk("same_busy", busy, 0);
    chk("same_tick", tick, 1);
    chk("same_cnt", tick_cnt, 1);
    req = 1'b0;
    step();                                     // E35
    chk("same_ack_drop", ack, 0);
    chk("same_busy2", busy, 0);
    chk("same_tick_lo", tick, 0);
    chk("same_cnt2", tick_cnt, 2);
    step();                                     // E36
    chk("same_tick_hi", tick, 1);
    step();                                     // E37
    chk("same_tick_lo2", tick, 0);
    chk("same_cnt3", tick_cnt, 3);

    // request div8, then freeze 20 cycles while waiting for alignment
    req = 1'b1; sel = 2'd3;
    step();                                     // E38
    chk("frz_busy", busy, 1);
    chk("frz_tick", tick, 1);
    req = 1'b0; run = 1'b0;
    for (int n = 39; n <= 58; n++) begin
      step();
      chk("frz_hold_busy", busy, 1);
      chk("frz_hold_noack", ack, 0);
      chk("frz_ticks_off", {tick, tick2, tick4}, 0);
    end
    chk("frz_cnt", tick_cnt, 4);
    run = 1'b1;
    step();                                     // E59: counter 6 -> 7
    chk("frz_resume_busy", busy, 1);
    chk("frz_resume_noack", ack, 0);
    step();                                     // E60: wrap edge
    chk("frz_ack", ack, 1);
    chk("frz_cur_sel", cur_sel, 3);
    chk("frz_cnt_clr", tick_cnt, 0);
    step();                                     // E61
    chk("frz_ack_drop", ack, 0);
    chk("frz_cnt1", tick_cnt, 1);

    // request div4, then a div8 request while busy must be ignored
    req = 1'b1; sel = 2'd2;
    step();                                     // E62
    chk("ign_busy", busy, 1);
    sel = 2'd3;
    step(2);                                    // E64
    chk("ign_busy2", busy, 1);
    req = 1'b0;
    step(4);                                    // E68
    chk("ign_ack", ack, 1);
    chk("ign_cur_sel", cur_sel, 2);
    chk("ign_cnt_clr", tick_cnt, 0);
    for (int n = 69; n <= 76; n++) begin
      step();
      chk("d4_tick", tick, (n == 72 || n == 76));
    end
    chk("d4_cnt", tick_cnt, 2);
    step();                                     // E77
    chk("d4_cnt2", tick_cnt, 3);

    // async reset while waiting for alignment
    req = 1'b1; sel = 2'd1;
    step();                                     // E78
    req = 1'b0;
    chk("ar_busy_pre", busy, 1);
    chk("ar_tick2_pre", tick2, 1);
    chk("ar_cnt_pre", tick_cnt, 3);
    #2 resetn = 1'b0;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_ack", ack, 0);
    chk("ar_tick", tick, 0);
    chk("ar_tick2", tick2, 0);
    chk("ar_tick4", tick4, 0);
    chk("ar_cnt", tick_cnt, 0);
    chk("ar_cur_sel", cur_sel, 0);
    step(2);
    chk("ar_hold_busy", busy, 0);
    @(negedge clk);
    resetn = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      step();
      chk("ar_post_noack", ack, 0);
      chk("ar_post_busy", busy, 0);
      chk("ar_post_sel", cur_sel, 0);
      chk("ar_post_tick", tick, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
